// File: rtl/var_delay_sat_if.sv
// Sample/delay-control bundle for var_delay_sat: the source drives samples and
// delay loads, and the delay line returns the delayed, saturated stream.
interface var_delay_sat_if #(
    parameter int IN_D_WIDTH  = 16,
    parameter int OUT_D_WIDTH = 10,
    parameter int AW          = 6
);
    logic                          vld;
    logic signed [IN_D_WIDTH-1:0]  din;
    logic                          delay_wr;
    logic        [AW-1:0]          delay;
    logic signed [OUT_D_WIDTH-1:0] dout;
    logic                          dout_vld;
    logic                          sat;
    logic                          primed;

    modport master (
        output vld, din, delay_wr, delay,
        input  dout, dout_vld, sat, primed
    );

    modport slave (
        input  vld, din, delay_wr, delay,
        output dout, dout_vld, sat, primed
    );
endinterface

// File: rtl/var_delay_sat.sv
// Variable delay line counted in valid samples, with signed saturation of the
// delayed sample down to the output width. Outputs are zero until primed.
module var_delay_sat #(
    parameter int IN_D_WIDTH    = 16,
    parameter int OUT_D_WIDTH   = 10,
    parameter int MAX_DELAY     = 64,
    parameter int DEFAULT_DELAY = 1
) (
    input  logic           clk,
    input  logic           reset,
    var_delay_sat_if.slave bus
);
    localparam int AW = $clog2(MAX_DELAY);

    localparam logic [AW-1:0] ONE     = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW-1:0] CNT_MAX = {AW{1'b1}};
    localparam logic signed [IN_D_WIDTH-1:0] SAT_HI =
        $signed({{(IN_D_WIDTH-OUT_D_WIDTH+1){1'b0}}, {(OUT_D_WIDTH-1){1'b1}}});
    localparam logic signed [IN_D_WIDTH-1:0] SAT_LO =
        $signed({{(IN_D_WIDTH-OUT_D_WIDTH+1){1'b1}}, {(OUT_D_WIDTH-1){1'b0}}});

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FILL  = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    // Returns {clipped_flag, value}; equal widths never clip since the limits
    // then coincide with the full input range.
    function automatic logic [OUT_D_WIDTH:0] sat_fn(input logic signed [IN_D_WIDTH-1:0] x);
        logic [OUT_D_WIDTH:0] r;
        if (x > SAT_HI) begin
            r = {1'b1, SAT_HI[OUT_D_WIDTH-1:0]};
        end else if (x < SAT_LO) begin
            r = {1'b1, SAT_LO[OUT_D_WIDTH-1:0]};
        end else begin
            r = {1'b0, x[OUT_D_WIDTH-1:0]};
        end
        return r;
    endfunction

    logic signed [IN_D_WIDTH-1:0]  mem_r [MAX_DELAY];
    logic        [AW-1:0]          wr_ptr_r;
    logic        [AW-1:0]          cnt_r;
    logic        [AW-1:0]          d_r;
    state_t                        state_r;
    logic signed [OUT_D_WIDTH-1:0] dout_r;
    logic                          dout_vld_r;
    logic                          sat_r;

    logic        [AW-1:0]          d_eff_s;
    logic        [AW-1:0]          cnt_nxt_s;
    logic        [AW-1:0]          rd_addr_s;
    logic signed [IN_D_WIDTH-1:0]  rd_data_s;
    logic        [OUT_D_WIDTH:0]   sat_res_s;
    logic                          out_en_s;
    state_t                        state_nxt_s;

    // Datapath: a delay load applies to the sample arriving in the same cycle.
    always_comb begin
        d_eff_s = d_r;
        if (bus.delay_wr) begin
            if (bus.delay == {AW{1'b0}}) begin
                d_eff_s = ONE;
            end else begin
                d_eff_s = bus.delay;
            end
        end else begin
            d_eff_s = d_r;
        end
        if (bus.vld && (cnt_r != CNT_MAX)) begin
            cnt_nxt_s = cnt_r + ONE;
        end else begin
            cnt_nxt_s = cnt_r;
        end
        rd_addr_s = wr_ptr_r - d_eff_s;
        rd_data_s = mem_r[rd_addr_s];
        sat_res_s = sat_fn(rd_data_s);
        out_en_s  = (cnt_r >= d_eff_s);
    end

    // Fill-state next-state logic, evaluated from the updated count and delay.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_EMPTY: begin
                if (bus.vld) begin
                    state_nxt_s = (cnt_nxt_s >= d_eff_s) ? ST_RUN : ST_FILL;
                end else begin
                    state_nxt_s = ST_EMPTY;
                end
            end
            ST_FILL, ST_RUN: begin
                if (cnt_nxt_s >= d_eff_s) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_FILL;
                end
            end
            default: state_nxt_s = ST_EMPTY;
        endcase
    end

    // Sample storage; contents are left stale across reset and masked by the fill count.
    always_ff @(posedge clk) begin
        if (bus.vld && !reset) begin
            mem_r[wr_ptr_r] <= bus.din;
        end
    end

    // Control state and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_EMPTY;
            wr_ptr_r   <= {AW{1'b0}};
            cnt_r      <= {AW{1'b0}};
            d_r        <= AW'(DEFAULT_DELAY);
            dout_r     <= {OUT_D_WIDTH{1'b0}};
            dout_vld_r <= 1'b0;
            sat_r      <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            d_r     <= d_eff_s;
            cnt_r   <= cnt_nxt_s;
            if (bus.vld) begin
                wr_ptr_r   <= wr_ptr_r + ONE;
                dout_vld_r <= 1'b1;
                if (out_en_s) begin
                    dout_r <= sat_res_s[OUT_D_WIDTH-1:0];
                    sat_r  <= sat_res_s[OUT_D_WIDTH];
                end else begin
                    dout_r <= {OUT_D_WIDTH{1'b0}};
                    sat_r  <= 1'b0;
                end
            end else begin
                dout_vld_r <= 1'b0;
                sat_r      <= 1'b0;
            end
        end
    end

    assign bus.dout     = dout_r;
    assign bus.dout_vld = dout_vld_r;
    assign bus.sat      = sat_r;
    assign bus.primed   = (state_r == ST_RUN);
endmodule
